// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core arbiter slice.
// Pure declarations: no latency or backpressure of its own.
package aes_pkg;

    localparam int   BLOCK_W  = 128;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    typedef logic [0:BLOCK_W-1] block_t;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Request, core and response signals of the AES arbiter, grouped per side.
// Wires only: timing and backpressure come from the attached modules.
interface aes_core_arbiter_if;

    logic            req0_valid;
    logic            req0_ready;
    aes_pkg::block_t req0_data;
    logic            req0_mode;

    logic            req1_valid;
    logic            req1_ready;
    aes_pkg::block_t req1_data;
    logic            req1_mode;

    logic            core_start;
    logic            core_mode;
    aes_pkg::block_t core_data;
    logic            core_done;
    aes_pkg::block_t core_result;

    logic            rsp_valid;
    logic            rsp_ready;
    aes_pkg::block_t rsp_data;
    logic            rsp_id;
    logic            rsp_err;

    // Arbiter view.
    modport slave (
        input  req0_valid, req0_data, req0_mode,
        output req0_ready,
        input  req1_valid, req1_data, req1_mode,
        output req1_ready,
        output core_start, core_mode, core_data,
        input  core_done, core_result,
        output rsp_valid, rsp_data, rsp_id, rsp_err,
        input  rsp_ready
    );

    // Host, core and consumer view.
    modport master (
        output req0_valid, req0_data, req0_mode,
        input  req0_ready,
        output req1_valid, req1_data, req1_mode,
        input  req1_ready,
        input  core_start, core_mode, core_data,
        output core_done, core_result,
        input  rsp_valid, rsp_data, rsp_id, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a lone requester wins, on contention ptr_i picks.
// Combinational, zero latency; no state, the pointer lives in the parent.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one iterative AES core between two requesters, one job in flight, round-robin.
// Grant->start 1 cycle, done->rsp_valid 1 cycle; no new grant until the response is taken.
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input logic               clks,
    input logic               reset,
    aes_core_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q,     state_d;
    logic             rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] wdog_q,      wdog_d;
    block_t           core_data_q, core_data_d;
    logic             core_mode_q, core_mode_d;
    block_t           rsp_data_q,  rsp_data_d;
    logic             rsp_id_q,    rsp_id_d;
    logic             rsp_err_q,   rsp_err_d;

    logic [1:0]       gnt;
    logic             in_idle;

    rr_arb2 u_arb (
        .valid_i ({bus.req1_valid, bus.req0_valid}),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (gnt)
    );

    // Handshake outputs are decoded from state and forced low while reset is held.
    assign in_idle        = (state_q == S_IDLE) && !reset;
    assign bus.req0_ready = in_idle && gnt[0];
    assign bus.req1_ready = in_idle && gnt[1];
    assign bus.core_start = (state_q == S_ISSUE) && !reset;
    assign bus.rsp_valid  = (state_q == S_RESP) && !reset;

    assign bus.core_data  = core_data_q;
    assign bus.core_mode  = core_mode_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_err    = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        wdog_d      = wdog_q;
        core_data_d = core_data_q;
        core_mode_d = core_mode_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (gnt != 2'b00) begin
                    core_data_d = gnt[1] ? bus.req1_data : bus.req0_data;
                    core_mode_d = gnt[1] ? bus.req1_mode : bus.req0_mode;
                    rsp_id_d    = gnt[1];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + CNT_W'(1);
                // A done arriving on the last watchdog cycle still counts as success.
                if (bus.core_done) begin
                    rsp_data_d = bus.core_result;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rr_ptr_d = ~rsp_id_q;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            wdog_q      <= '0;
            core_data_q <= '0;
            core_mode_q <= MODE_ENC;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            wdog_q      <= wdog_d;
            core_data_q <= core_data_d;
            core_mode_q <= core_mode_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
